// File: rtl/u711_regsize_if.sv
// CPU-side and cycle-generator-side signals of the U711 register bus sizer.
interface u711_regsize_if;
  // CPU local-bus side
  logic        nTS;
  logic        nREGSEL;
  logic        RnW;
  logic [1:0]  A;
  logic [1:0]  SIZ;
  logic [31:0] DIN;
  logic [31:0] DOUT;
  logic        nTA;
  logic        nTEA;
  // cycle-generator side
  logic        nREGEN;
  logic [1:0]  A_SUB;
  logic [1:0]  SIZ_SUB;
  logic        RnW_SUB;
  logic [15:0] WDATA16;
  logic [15:0] RDATA16;
  logic        nSUBTA;

  modport master (
    output nTS, nREGSEL, RnW, A, SIZ, DIN, RDATA16, nSUBTA,
    input  DOUT, nTA, nTEA, nREGEN, A_SUB, SIZ_SUB, RnW_SUB, WDATA16
  );

  modport slave (
    input  nTS, nREGSEL, RnW, A, SIZ, DIN, RDATA16, nSUBTA,
    output DOUT, nTA, nTEA, nREGEN, A_SUB, SIZ_SUB, RnW_SUB, WDATA16
  );
endinterface

// File: rtl/u711_regsize.sv
// Splits a 68040 chip-register transfer into 16-bit sub-cycles for the U711 cycle generator,
// assembles read data and terminates the CPU cycle with nTA, or nTEA on illegal size / timeout.
module u711_regsize #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           CLK40,
  input  logic           RESET,
  u711_regsize_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SUB1, GAP, SUB2, ACK, ERR} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  a_q;
  logic [1:0]  siz_q;
  logic        rnw_q;
  logic [31:0] din_q;
  logic        acked;
  logic [7:0]  wdog;

  logic        is_long;
  logic        second;
  logic [1:0]  sub_a;
  logic [1:0]  sub_siz;
  logic [15:0] sub_wd;

  function automatic logic legal(input logic [1:0] a, input logic [1:0] siz);
    case (siz)
      2'b00:   return (a == 2'b00);
      2'b01:   return 1'b1;
      2'b10:   return !a[0];
      default: return 1'b0;
    endcase
  endfunction

  assign is_long = (siz_q == 2'b00);
  assign second  = (state == GAP);

  // Sub-cycle attributes are loaded on the edge that drops nREGEN (from SUB1 or GAP).
  always_comb begin
    sub_a   = a_q;
    sub_siz = siz_q;
    sub_wd  = a_q[1] ? din_q[15:0] : din_q[31:16];
    if (is_long) begin
      sub_siz = 2'b10;
      sub_a   = second ? 2'b10 : 2'b00;
      sub_wd  = second ? din_q[15:0] : din_q[31:16];
    end
  end

  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      a_q         <= 2'b00;
      siz_q       <= 2'b00;
      rnw_q       <= 1'b1;
      din_q       <= 32'd0;
      acked       <= 1'b0;
      wdog        <= 8'd0;
      bus.nREGEN  <= 1'b1;
      bus.nTA     <= 1'b1;
      bus.nTEA    <= 1'b1;
      bus.A_SUB   <= 2'b00;
      bus.SIZ_SUB <= 2'b00;
      bus.RnW_SUB <= 1'b1;
      bus.WDATA16 <= 16'd0;
      bus.DOUT    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.nTS && !bus.nREGSEL) begin
            a_q   <= bus.A;
            siz_q <= bus.SIZ;
            rnw_q <= bus.RnW;
            din_q <= bus.DIN;
            state <= legal(bus.A, bus.SIZ) ? SUB1 : ERR;
          end
        end

        SUB1, SUB2: begin
          if (bus.nREGEN) begin
            bus.nREGEN  <= 1'b0;
            bus.A_SUB   <= sub_a;
            bus.SIZ_SUB <= sub_siz;
            bus.RnW_SUB <= rnw_q;
            bus.WDATA16 <= sub_wd;
            wdog        <= 8'd0;
          end else if (acked) begin
            // acknowledge is registered one cycle before nREGEN is released
            bus.nREGEN <= 1'b1;
            acked      <= 1'b0;
            if (state == SUB1 && is_long) begin
              state <= GAP;
            end else begin
              state   <= ACK;
              bus.nTA <= 1'b0;
            end
          end else if (!bus.nSUBTA) begin
            acked <= 1'b1;
            if (rnw_q) begin
              if (!is_long)
                bus.DOUT <= {bus.RDATA16, bus.RDATA16};
              else if (state == SUB1)
                bus.DOUT[31:16] <= bus.RDATA16;
              else
                bus.DOUT[15:0] <= bus.RDATA16;
            end
          end else if (wdog == WD_LAST) begin
            wdog       <= wdog + 8'd1;
            bus.nREGEN <= 1'b1;
            bus.nTEA   <= 1'b0;
            state      <= ERR;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end

        GAP: begin
          bus.nREGEN  <= 1'b0;
          bus.A_SUB   <= sub_a;
          bus.SIZ_SUB <= sub_siz;
          bus.RnW_SUB <= rnw_q;
          bus.WDATA16 <= sub_wd;
          wdog        <= 8'd0;
          state       <= SUB2;
        end

        ACK: begin
          bus.nTA <= 1'b1;
          state   <= IDLE;
        end

        ERR: begin
          // timeout enters with nTEA already low; an illegal size drops it here
          if (bus.nTEA) begin
            bus.nTEA <= 1'b0;
          end else begin
            bus.nTEA <= 1'b1;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_u711_regsize.sv
// Randomized scoreboard bench for u711_regsize with a generator model and a CPU-side monitor.
module tb_u711_regsize;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  u711_regsize_if bus();

  u711_regsize #(.TIMEOUT(TMO)) dut (
    .CLK40 (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  a;
    logic [1:0]  siz;
    logic        rnw;
    logic [15:0] wd;
    logic [15:0] rd;
    int          lat;    // negative: never acknowledge
    bit          first;
  } sub_t;

  typedef struct {
    bit          err;
    logic [31:0] dout;
    int          tchk;   // 0 none, 1 relative to nTS, 2 relative to last nSUBTA
  } resp_t;

  sub_t        subq[$];
  resp_t       respq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ts_cyc = 0;
  int          ack_cyc = 0;
  int          rel_cyc = 0;
  bit          gen_en = 0;
  logic [31:0] model_dout = 32'd0;
  resp_t       mon_r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset();
    chk("rst_nREGEN", {31'd0, bus.nREGEN}, 32'd1);
    chk("rst_nTA", {31'd0, bus.nTA}, 32'd1);
    chk("rst_nTEA", {31'd0, bus.nTEA}, 32'd1);
    chk("rst_A_SUB", {30'd0, bus.A_SUB}, 32'd0);
    chk("rst_SIZ_SUB", {30'd0, bus.SIZ_SUB}, 32'd0);
    chk("rst_RnW_SUB", {31'd0, bus.RnW_SUB}, 32'd1);
    chk("rst_WDATA16", {16'd0, bus.WDATA16}, 32'd0);
    chk("rst_DOUT", bus.DOUT, 32'd0);
  endtask

  // CPU-side monitor: every low cycle of nTA/nTEA consumes one expected response.
  always @(negedge clk) begin
    if (!rst && (bus.nTA === 1'b0 || bus.nTEA === 1'b0)) begin
      chk("ta_tea_exclusive", {31'd0, bus.nTA | bus.nTEA}, 32'd1);
      if (respq.size() == 0) begin
        chk("unexpected_ack", {30'd0, bus.nTA, bus.nTEA}, 32'd3);
      end else begin
        mon_r = respq.pop_front();
        chk("resp_kind", {31'd0, ~bus.nTEA}, {31'd0, mon_r.err});
        if (mon_r.tchk == 1) chk("tea_latency", 32'(cyc - ts_cyc), 32'd1);
        if (mon_r.tchk == 2) chk("ta_latency", 32'(cyc - ack_cyc), 32'd1);
        chk("dout", bus.DOUT, mon_r.dout);
      end
    end
  end

  // Cycle-generator model: checks each sub-cycle request and answers it as planned.
  task automatic run_sub();
    sub_t s;
    int   low;
    int   g;
    if (subq.size() == 0) begin
      chk("unexpected_subcycle", {31'd0, bus.nREGEN}, 32'd1);
      g = 0;
      while (bus.nREGEN === 1'b0 && g < 300) begin @(negedge clk); g++; end
      rel_cyc = cyc;
      return;
    end
    s = subq.pop_front();
    chk("sub_start", s.first ? 32'(cyc - ts_cyc) : 32'(cyc - rel_cyc), 32'd1);
    chk("A_SUB", {30'd0, bus.A_SUB}, {30'd0, s.a});
    chk("SIZ_SUB", {30'd0, bus.SIZ_SUB}, {30'd0, s.siz});
    chk("RnW_SUB", {31'd0, bus.RnW_SUB}, {31'd0, s.rnw});
    chk("WDATA16", {16'd0, bus.WDATA16}, {16'd0, s.wd});
    if (s.lat < 0) begin
      low = 1;
      while (bus.nREGEN === 1'b0 && low < 300) begin
        @(negedge clk);
        if (bus.nREGEN === 1'b0) low++;
      end
      chk("wdog_len", 32'(low), 32'(TMO));
    end else begin
      repeat (s.lat) @(negedge clk);
      bus.nSUBTA  = 1'b0;
      bus.RDATA16 = s.rd;
      @(negedge clk);
      ack_cyc     = cyc;
      bus.nSUBTA  = 1'b1;
      bus.RDATA16 = 16'($urandom);
      g = 0;
      while (bus.nREGEN === 1'b0 && g < 20) begin @(negedge clk); g++; end
      chk("release", 32'(cyc - ack_cyc), 32'd1);
    end
    rel_cyc = cyc;
  endtask

  initial begin
    bus.nSUBTA  = 1'b1;
    bus.RDATA16 = 16'd0;
    forever begin
      @(negedge clk);
      if (gen_en && !rst && bus.nREGEN === 1'b0) run_sub();
    end
  end

  task automatic wait_done();
    int g;
    g = 0;
    while ((respq.size() != 0 || subq.size() != 0) && g < 500) begin @(negedge clk); g++; end
    chk("drain", 32'(respq.size() + subq.size()), 32'd0);
    respq.delete();
    subq.delete();
    repeat (2) @(negedge clk);
  endtask

  // Reference model: expected sub-cycles and termination derived from the sizing rules.
  task automatic issue(input bit rnw, input bit [1:0] a, input bit [1:0] siz, input bit [31:0] din,
                       input bit [15:0] r1, input bit [15:0] r2, input int l1, input int l2,
                       input bit spur);
    bit    lng, ok, tmo;
    sub_t  s;
    resp_t r;
    int    g;
    lng = (siz == 2'b00);
    ok  = (siz == 2'b01) || (siz == 2'b10 && !a[0]) || (lng && a == 2'b00);
    if (ok) begin
      if (lng) begin
        s = '{a:2'b00, siz:2'b10, rnw:rnw, wd:din[31:16], rd:r1, lat:l1, first:1'b1};
        subq.push_back(s);
        if (l1 >= 0) begin
          s = '{a:2'b10, siz:2'b10, rnw:rnw, wd:din[15:0], rd:r2, lat:l2, first:1'b0};
          subq.push_back(s);
        end
      end else begin
        s = '{a:a, siz:siz, rnw:rnw, wd:(a[1] ? din[15:0] : din[31:16]), rd:r1, lat:l1, first:1'b1};
        subq.push_back(s);
      end
      tmo = (l1 < 0) || (lng && l2 < 0);
      if (rnw && !tmo) model_dout = lng ? {r1, r2} : {r1, r1};
      else if (rnw && lng && l1 >= 0 && l2 < 0) model_dout[31:16] = r1;
      r = '{err:tmo, dout:model_dout, tchk:(tmo ? 0 : 2)};
    end else begin
      r = '{err:1'b1, dout:model_dout, tchk:1};
    end
    respq.push_back(r);
    @(negedge clk);
    bus.nTS = 1'b0; bus.nREGSEL = 1'b0; bus.RnW = rnw; bus.A = a; bus.SIZ = siz; bus.DIN = din;
    @(negedge clk);
    ts_cyc = cyc;
    bus.nTS = 1'b1; bus.nREGSEL = 1'($urandom); bus.DIN = $urandom;
    bus.A = 2'($urandom); bus.SIZ = 2'($urandom); bus.RnW = 1'($urandom);
    if (spur && ok) begin
      g = 0;
      while (bus.nREGEN !== 1'b0 && g < 20) begin @(negedge clk); g++; end
      bus.nTS = 1'b0; bus.nREGSEL = 1'b0; bus.A = 2'($urandom); bus.SIZ = 2'($urandom);
      @(negedge clk);
      bus.nTS = 1'b1;
    end
    wait_done();
  endtask

  task automatic ignored();
    @(negedge clk);
    bus.nTS = 1'b0; bus.nREGSEL = 1'b1; bus.SIZ = 2'($urandom); bus.A = 2'($urandom);
    @(negedge clk);
    bus.nTS = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("regsel_idle", {31'd0, bus.nREGEN}, 32'd1);
    end
  endtask

  task automatic reset_mid_long();
    int g;
    gen_en = 0;
    @(negedge clk);
    bus.nTS = 1'b0; bus.nREGSEL = 1'b0; bus.RnW = 1'b1; bus.A = 2'b00; bus.SIZ = 2'b00;
    @(negedge clk);
    bus.nTS = 1'b1; bus.nREGSEL = 1'b1;
    g = 0;
    while (bus.nREGEN !== 1'b0 && g < 20) begin @(negedge clk); g++; end
    bus.nSUBTA = 1'b0; bus.RDATA16 = 16'h1234;
    @(negedge clk);
    bus.nSUBTA = 1'b1;
    g = 0;
    while (bus.nREGEN === 1'b0 && g < 20) begin @(negedge clk); g++; end
    g = 0;
    while (bus.nREGEN !== 1'b0 && g < 20) begin @(negedge clk); g++; end
    @(negedge clk);
    chk("sub2_active", {31'd0, bus.nREGEN}, 32'd0);
    #2 rst = 1'b1;
    #1 chk_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.nSUBTA = 1'b0; bus.RDATA16 = 16'hDEAD;
    @(negedge clk);
    bus.nSUBTA = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_nREGEN", {31'd0, bus.nREGEN}, 32'd1);
      chk("post_rst_nTA", {31'd0, bus.nTA}, 32'd1);
      chk("post_rst_DOUT", bus.DOUT, 32'd0);
    end
    model_dout = 32'd0;
    gen_en = 1;
  endtask

  bit        rr_rnw, rr_spur;
  bit [1:0]  rr_a, rr_siz;
  bit [31:0] rr_din;
  bit [15:0] rr_r1, rr_r2;

  initial begin
    bus.nTS = 1'b1; bus.nREGSEL = 1'b1; bus.RnW = 1'b1;
    bus.A = 2'b00; bus.SIZ = 2'b00; bus.DIN = 32'd0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    gen_en = 1;
    @(negedge clk);

    issue(1, 2'b00, 2'b00, 32'h0, 16'h1234, 16'hABCD, 2, 1, 0);
    issue(0, 2'b10, 2'b10, 32'h11223344, 16'h0, 16'h0, 1, 0, 0);
    issue(1, 2'b01, 2'b01, 32'h0, 16'h00EE, 16'h0, 0, 0, 0);
    issue(0, 2'b10, 2'b00, 32'h55667788, 16'h0, 16'h0, 0, 0, 0);
    issue(1, 2'b01, 2'b10, 32'h0, 16'h0, 16'h0, 0, 0, 0);
    issue(1, 2'b00, 2'b11, 32'h0, 16'h0, 16'h0, 0, 0, 0);
    issue(1, 2'b00, 2'b10, 32'h0, 16'h9999, 16'h0, -1, 0, 0);
    issue(1, 2'b10, 2'b10, 32'h0, 16'h4321, 16'h0, 3, 0, 0);
    issue(1, 2'b00, 2'b00, 32'h0, 16'h7777, 16'h0, 1, -1, 0);
    issue(1, 2'b00, 2'b10, 32'h0, 16'h5A5A, 16'h0, TMO - 1, 0, 0);
    issue(0, 2'b11, 2'b01, 32'hCAFEF00D, 16'h0, 16'h0, TMO - 2, 0, 0);
    issue(0, 2'b00, 2'b00, 32'hDEADBEEF, 16'h0, 16'h0, 0, 2, 1);
    ignored();
    reset_mid_long();
    issue(1, 2'b00, 2'b00, 32'h0, 16'h0F0F, 16'hF0F0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rr_rnw  = 1'($urandom);
      rr_a    = 2'($urandom);
      rr_siz  = 2'($urandom);
      rr_din  = $urandom;
      rr_r1   = 16'($urandom);
      rr_r2   = 16'($urandom);
      rr_spur = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0)
        ignored();
      else
        issue(rr_rnw, rr_a, rr_siz, rr_din, rr_r1, rr_r2,
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), rr_spur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
